// File: rtl/mano_mem_master_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mano_mem_master_if                                                     |
// | Request port and memory-bus bundle for mano_mem_master.                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface mano_mem_master_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;

    // Controller side: takes requests, drives the memory.
    modport master (
        input  req, we, addr_in, wdata, mem_dout,
        output rdata, busy, done, err, mem_addr, mem_rd, mem_wr, mem_din
    );

    // Environment side: requester plus the memory itself.
    modport slave (
        output req, we, addr_in, wdata, mem_dout,
        input  rdata, busy, done, err, mem_addr, mem_rd, mem_wr, mem_din
    );
endinterface
`default_nettype wire

// File: rtl/mano_mem_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mano_mem_master                                                        |
// | Single-word read/write controller for a 4096x16 async-read memory.     |
// | Option: MANO_WR_VERIFY_EN adds a readback VERIFY cycle after writes.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mano_mem_master #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mano_mem_master_if.master bus
);
    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_READ   = 3'd1;
    localparam logic [2:0] c_WRITE  = 3'd2;
`ifdef MANO_WR_VERIFY_EN
    localparam logic [2:0] c_VERIFY = 3'd3;
`endif
    localparam logic [2:0] c_DONE   = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_mem_rd;
    logic                  w_mem_wr;
    logic                  w_accept;

    assign w_accept = (r_state == c_IDLE) && bus.req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (bus.req) w_state_nxt = bus.we ? c_WRITE : c_READ;
            c_READ:   w_state_nxt = c_DONE;
`ifdef MANO_WR_VERIFY_EN
            c_WRITE:  w_state_nxt = c_VERIFY;
            c_VERIFY: w_state_nxt = c_DONE;
`else
            c_WRITE:  w_state_nxt = c_DONE;
`endif
            c_DONE:   w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = 1'b0;
        w_done   = 1'b0;
        w_mem_rd = 1'b0;
        w_mem_wr = 1'b0;
        case (r_state)
            c_READ: begin
                w_busy   = 1'b1;
                w_mem_rd = 1'b1;
            end
            c_WRITE: begin
                w_busy   = 1'b1;
                w_mem_wr = 1'b1;
            end
`ifdef MANO_WR_VERIFY_EN
            c_VERIFY: begin
                w_busy   = 1'b1;
                w_mem_rd = 1'b1;
            end
`endif
            c_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // Address and write data stay put after DONE until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_mem_addr <= bus.addr_in;
                r_mem_din  <= bus.wdata;
            end
            if (r_state == c_READ) begin
                r_rdata <= bus.mem_dout;
            end
`ifdef MANO_WR_VERIFY_EN
            if (r_state == c_VERIFY) begin
                r_rdata <= bus.mem_dout;
            end
`endif
        end
    end

`ifdef MANO_WR_VERIFY_EN
    logic r_err;

    // Compare against the latched write word, not the live wdata input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= 1'b0;
        end else if (r_state == c_VERIFY) begin
            r_err <= (bus.mem_dout != r_mem_din);
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.rdata    = r_rdata;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_rd   = w_mem_rd;
    assign bus.mem_wr   = w_mem_wr;
    assign bus.mem_din  = r_mem_din;
endmodule
`default_nettype wire

// File: tb/tb_mano_mem_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mano_mem_master                                                     |
// | Directed bench with a 4096x16 memory model and a completion scoreboard.|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mano_mem_master;
`ifdef MANO_WR_VERIFY_EN
    localparam int c_WR_LAT = 3;
`else
    localparam int c_WR_LAT = 2;
`endif
    localparam int c_RD_LAT = 2;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] mem [4096];
    logic        stuck0;
    exp_t        exp_q [$];
    logic [15:0] m_rdata;
    int          vectors;
    int          miscompares;

    mano_mem_master_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

    mano_mem_master #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: async read, optional bit-0 stuck-at-0 on the read path.
    assign bus.mem_dout = mem[bus.mem_addr] & {15'h7FFF, ~stuck0};
    always @(posedge clk) begin
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("rd_wr_overlap", {31'b0, bus.mem_rd & bus.mem_wr}, 32'd0);
        if (bus.done) begin
            check("done_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_rdata", {16'b0, bus.rdata}, {16'b0, e.rdata});
                check("sb_err", {31'b0, bus.err}, {31'b0, e.err});
            end
        end
    end

    task automatic txn(input logic w, input logic [11:0] a, input logic [15:0] d, input string tag);
        exp_t e;
        int   wr;
        int   lat;
        bit   seen;
        if (w) begin
`ifdef MANO_WR_VERIFY_EN
            m_rdata = stuck0 ? (d & 16'hFFFE) : d;
            e.err   = stuck0 && d[0];
`else
            e.err   = 1'b0;
`endif
        end else begin
            m_rdata = mem[a] & {15'h7FFF, ~stuck0};
            e.err   = 1'b0;
        end
        e.rdata = m_rdata;
        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr_in = a; bus.wdata = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1 bus.req = 1'b0;
        wr = 0; lat = 0; seen = 1'b0;
        for (int n = 1; n <= 8 && !seen; n++) begin
            @(negedge clk);
            if (n == 1) check({tag, "_err_clr"}, {31'b0, bus.err}, 32'd0);
            if (bus.mem_wr) wr++;
            if (bus.done) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        check({tag, "_latency"}, lat, w ? c_WR_LAT : c_RD_LAT);
        check({tag, "_wr_cycles"}, wr, w ? 1 : 0);
        @(posedge clk);
    endtask

    initial begin
        int dones;
        vectors = 0; miscompares = 0; stuck0 = 1'b0; m_rdata = 16'h0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[12'h010] = 16'h7A3C;
        mem[12'h001] = 16'h1111;
        mem[12'h002] = 16'h2222;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr_in = '0; bus.wdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        check("rst_rdata", {16'b0, bus.rdata}, 32'd0);
        check("rst_mem_addr", {20'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_din", {16'b0, bus.mem_din}, 32'd0);
        check("rst_mem_rdwr", {30'b0, bus.mem_rd, bus.mem_wr}, 32'd0);
        rst = 1'b0;

        txn(1'b0, 12'h010, 16'h0000, "rd_010");
        txn(1'b1, 12'hFFF, 16'hBEEF, "wr_fff");
        txn(1'b0, 12'hFFF, 16'h0000, "rd_fff");
        @(negedge clk);
        check("hold_mem_addr", {20'b0, bus.mem_addr}, 32'h0FFF);
        check("hold_mem_din", {16'b0, bus.mem_din}, 32'h0000);
        txn(1'b1, 12'h000, 16'h1234, "wr_000");
        check("hold_din_after_wr", {16'b0, bus.mem_din}, 32'h1234);
        txn(1'b1, 12'h800, 16'h5555, "wr_800");
        txn(1'b0, 12'h000, 16'h0000, "rd_000");
        txn(1'b0, 12'h800, 16'h0000, "rd_800");

`ifdef MANO_WR_VERIFY_EN
        stuck0 = 1'b1;
        txn(1'b1, 12'h020, 16'h0001, "wr_stuck");
        check("stuck_err_held", {31'b0, bus.err}, 32'd1);
        stuck0 = 1'b0;
        txn(1'b0, 12'h010, 16'h0000, "rd_after_err");
`endif

        // req held high: accepts only from IDLE, at edges 0, 3 and 6.
        exp_q.push_back('{16'h1111, 1'b0});
        exp_q.push_back('{16'h1111, 1'b0});
        exp_q.push_back('{16'h2222, 1'b0});
        m_rdata = 16'h2222;
        dones = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
            bus.req = 1'b1; bus.we = 1'b0;
            bus.addr_in = (i < 6) ? 12'h001 : 12'h002;
            @(posedge clk);
        end
        #1 bus.req = 1'b0;
        @(negedge clk);
        if (bus.done) dones++;
        check("held_req_dones", dones, 3);
        check("held_req_sb_empty", exp_q.size(), 0);

        // Reset closing a READ cycle aborts it with no done.
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr_in = 12'h010;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        check("mid_read_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_rdata", {16'b0, bus.rdata}, 32'd0);
        bus.req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.req = 1'b0;
        check("rst_req_dropped", {31'b0, bus.busy}, 32'd0);
        @(negedge clk);
        check("rst_req_no_rd", {31'b0, bus.mem_rd}, 32'd0);

        // Reset closing a WRITE cycle still commits that write.
        bus.req = 1'b1; bus.we = 1'b1; bus.addr_in = 12'h030; bus.wdata = 16'hCAFE;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(negedge clk);
        check("rst_wr_mem_wr", {31'b0, bus.mem_wr}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wr_commit", {16'b0, mem[12'h030]}, 32'h0000CAFE);
        @(negedge clk);
        rst = 1'b0;
        check("rst_wr_din", {16'b0, bus.mem_din}, 32'd0);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.mem_wr || bus.done) dones++;
        end
        check("rst_wr_no_followup", dones, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mano_mem_master.md
MANO_MEM_MASTER -- requirements
Module: mano_mem_master

Interface
REQ-001 Widths SHALL come from the shared parameter definitions: addrwidth = 12, datawidth = 16.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock, shared with the 4096x16 memory.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  1  request strobe; accepted only in IDLE.
REQ-006 we  input  1  sampled with req: 1 = write, 0 = read.
REQ-007 addr_in  input  12  target word address, sampled with req.
REQ-008 wdata  input  16  write data, sampled with req.
REQ-009 rdata  output  16  last read (or verify readback) word, registered.
REQ-010 busy  output  1  high while a transaction is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  write-verify mismatch flag.
REQ-013 mem_addr  output  12  memory address, registered.
REQ-014 mem_rd  output  1  memory read enable.
REQ-015 mem_wr  output  1  memory write enable; the memory writes on the rising edge while it is high.
REQ-016 mem_din  output  16  memory write data, registered.
REQ-017 mem_dout  input  16  memory read data; combinational from mem_addr, so it is valid in the same cycle.

Function
REQ-018 The state machine SHALL have the states IDLE, READ, WRITE, VERIFY and DONE.
REQ-019 In IDLE, req=1 at an edge SHALL latch addr_in into mem_addr, wdata into mem_din and we, then go to READ (we=0) or WRITE (we=1).
REQ-020 READ SHALL last one cycle with mem_rd=1; at its closing edge mem_dout is captured into rdata and the state goes to DONE.
REQ-021 WRITE SHALL last exactly one cycle with mem_wr=1, then go to VERIFY (macro defined) or DONE.
REQ-022 DONE SHALL drive done=1 for exactly one cycle, then return to IDLE.
REQ-023 Read latency: request edge k -> rdata valid and done=1 in the cycle after edge k+1; IDLE after edge k+2.
REQ-024 busy SHALL be 1 in READ, WRITE and VERIFY, and 0 in IDLE and DONE.
REQ-025 mem_rd and mem_wr SHALL be Moore outputs of the state, never both high, and 0 in IDLE and DONE.
REQ-026 req SHALL be ignored while busy=1 and in DONE; no request is queued.
REQ-027 Back-to-back transactions: the minimum request spacing SHALL be 3 cycles, or 4 for a verified write.
REQ-028 mem_addr and mem_din SHALL hold their values after DONE until the next accepted request.
REQ-029 All 4096 addresses, including 12'hFFF, SHALL be legal; no address arithmetic is performed.
REQ-030 err SHALL clear when a new request is accepted.

Reset
REQ-031 On rst=1 at an edge the state SHALL go to IDLE, and rdata, mem_addr and mem_din SHALL go to 0.
REQ-032 On rst=1 at an edge busy, done, err, mem_rd and mem_wr SHALL go to 0; rst overrides a simultaneous req.
REQ-033 Reset mid-operation aborts the transaction; no done pulse is generated for it.
REQ-034 If the reset edge closes a WRITE cycle, the memory commits that write; no later write occurs.

Configuration
REQ-035 Macro MANO_WR_VERIFY_EN defined: after WRITE, VERIFY SHALL last one cycle with mem_rd=1.
REQ-036 In VERIFY, mem_dout SHALL be captured into rdata; err is set to 1 if mem_dout != latched wdata; then go to DONE.
REQ-037 With the macro defined, write latency SHALL be done=1 in the cycle after edge k+2.
REQ-038 Macro MANO_WR_VERIFY_EN undefined: the VERIFY state SHALL be absent, err is tied to 0, and write latency equals read latency.

Verification
REQ-039 Memory preloaded with word 16'h7A3C at address 12'h010; req=1, we=0, addr_in=12'h010 -> done pulses 2 cycles later, rdata=16'h7A3C, mem_wr never high.
REQ-040 Write 16'hBEEF to address 12'hFFF -> mem_wr high for exactly one cycle; a subsequent read returns 16'hBEEF; with the macro, err=0 and done arrives 1 cycle later.
REQ-041 Macro defined, bench memory model forces bit 0 stuck at 0; write 16'h0001 -> err=1 and rdata=16'h0000; the next accepted req clears err.
REQ-042 req held high continuously with 12'h001, then 12'h002 -> only the IDLE-time request is accepted per transaction, one done per transaction, and no overlap of mem_rd/mem_wr.
REQ-043 rst asserted in a READ cycle -> next cycle in IDLE, busy=0, done=0, rdata=0; rst with req in the same cycle -> request dropped.
